// File: rtl/instruction_queue.sv
// -----------------------------------------------------------------------------
// instruction_queue
//
// Prefetch queue in front of an instruction register (IR). A producer pushes
// instruction words into a circular buffer of DEPTH entries; LoadIR moves the
// oldest queued word into the IR, whose fields are presented as opcode and
// data_out.
//
// Handshake: a word transfers on a rising edge where ins_valid && ins_ready
// are both high. ins_ready is a pure combinational decode of the registered
// count (!full) and never depends on ins_valid, so the producer may hold
// ins_valid and its word stable until the transfer happens.
//
// Ports
//   clock        rising-edge clock
//   reset        synchronous active-high reset (highest priority)
//   instruction  incoming word, INS_WIDTH bits
//   ins_valid    producer offers instruction this cycle
//   ins_ready    queue can accept a word this cycle (= !full)
//   LoadIR       move queue head into IR (ignored while empty)
//   flush        discard queued words, clear ir_valid, keep IR contents
//   opcode       IR[INS_WIDTH-1 -: OPCODE_WIDTH]
//   data_out     IR[INS_WIDTH-OPCODE_WIDTH-1:0]
//   ir_valid     IR holds a word loaded since the last reset/flush
//   count        occupied entries, 0..DEPTH
//   full, empty  decodes of count
//   load_miss    one-cycle pulse after LoadIR was sampled on an empty queue
// -----------------------------------------------------------------------------
module instruction_queue #(
  parameter int INS_WIDTH    = 8,
  parameter int OPCODE_WIDTH = 4,
  parameter int DEPTH        = 4
) (
  input  logic                              clock,
  input  logic                              reset,
  input  logic [INS_WIDTH-1:0]              instruction,
  input  logic                              ins_valid,
  output logic                              ins_ready,
  input  logic                              LoadIR,
  input  logic                              flush,
  output logic [OPCODE_WIDTH-1:0]           opcode,
  output logic [INS_WIDTH-OPCODE_WIDTH-1:0] data_out,
  output logic                              ir_valid,
  output logic [$clog2(DEPTH):0]            count,
  output logic                              full,
  output logic                              empty,
  output logic                              load_miss
);

  localparam int PW = $clog2(DEPTH);
  localparam int CW = PW + 1;

  logic [INS_WIDTH-1:0] mem [DEPTH];
  logic [PW-1:0]        head;
  logic [PW-1:0]        tail;
  logic [INS_WIDTH-1:0] ir;
  logic                 push;
  logic                 pop;

  assign full      = (count == CW'(DEPTH));
  assign empty     = (count == '0);
  assign ins_ready = !full;

  // pop is gated by the registered empty, so a word pushed in the same cycle
  // is never bypassed straight into the IR.
  assign push = ins_valid && ins_ready;
  assign pop  = LoadIR && !empty;

  assign opcode   = ir[INS_WIDTH-1 -: OPCODE_WIDTH];
  assign data_out = ir[INS_WIDTH-OPCODE_WIDTH-1:0];

  // Storage carries no reset; only pointers and count give it meaning.
  // A flush or reset cycle never writes.
  always_ff @(posedge clock) begin
    if (!reset && !flush && push) begin
      mem[tail] <= instruction;
    end
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      head      <= '0;
      tail      <= '0;
      count     <= '0;
      ir        <= '0;
      ir_valid  <= 1'b0;
      load_miss <= 1'b0;
    end else if (flush) begin
      // IR contents deliberately survive a flush; only its valid is dropped.
      head      <= '0;
      tail      <= '0;
      count     <= '0;
      ir_valid  <= 1'b0;
      load_miss <= 1'b0;
    end else begin
      // DEPTH is a power of two, so pointer increments wrap on their own.
      if (push) begin
        tail <= tail + PW'(1);
      end
      if (pop) begin
        ir       <= mem[head];
        ir_valid <= 1'b1;
        head     <= head + PW'(1);
      end
      load_miss <= LoadIR && empty;
      case ({push, pop})
        2'b10:   count <= count + CW'(1);
        2'b01:   count <= count - CW'(1);
        default: count <= count;
      endcase
    end
  end

endmodule

// File: tb/tb_instruction_queue.sv
// -----------------------------------------------------------------------------
// tb_instruction_queue
//
// Bench for instruction_queue at the default 8/4/4 configuration. A queue
// based reference model runs alongside the DUT for every cycle; table vectors
// and hand sequences add hard-coded expected values on top of it, and a
// randomized phase compares the DUT against the model alone.
// -----------------------------------------------------------------------------
module tb_instruction_queue;

  localparam int INS_WIDTH    = 8;
  localparam int OPCODE_WIDTH = 4;
  localparam int DEPTH        = 4;
  localparam int DW           = INS_WIDTH - OPCODE_WIDTH;
  localparam int CW           = $clog2(DEPTH) + 1;

  // ---------------- clock / reset / DUT ----------------
  logic                    clock = 1'b0;
  logic                    reset;
  logic [INS_WIDTH-1:0]    instruction;
  logic                    ins_valid;
  logic                    ins_ready;
  logic                    LoadIR;
  logic                    flush;
  logic [OPCODE_WIDTH-1:0] opcode;
  logic [DW-1:0]           data_out;
  logic                    ir_valid;
  logic [CW-1:0]           count;
  logic                    full;
  logic                    empty;
  logic                    load_miss;

  always #5 clock = ~clock;

  instruction_queue #(
    .INS_WIDTH   (INS_WIDTH),
    .OPCODE_WIDTH(OPCODE_WIDTH),
    .DEPTH       (DEPTH)
  ) dut (
    .clock      (clock),
    .reset      (reset),
    .instruction(instruction),
    .ins_valid  (ins_valid),
    .ins_ready  (ins_ready),
    .LoadIR     (LoadIR),
    .flush      (flush),
    .opcode     (opcode),
    .data_out   (data_out),
    .ir_valid   (ir_valid),
    .count      (count),
    .full       (full),
    .empty      (empty),
    .load_miss  (load_miss)
  );

  // ---------------- scoreboard / reference model ----------------
  logic [INS_WIDTH-1:0] exp_q[$];   // words currently held by the queue
  logic [INS_WIDTH-1:0] m_ir   = '0;
  logic                 m_irv  = 1'b0;
  logic                 m_miss = 1'b0;

  int checks = 0;
  int errors = 0;

  task automatic chk(input string name, input int act, input int exp);
    checks++;
    if (act != exp) begin
      errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
    end
  endtask

  // One clock of the queue's rules, described in terms of words held.
  task automatic model_step(input logic v, input logic [INS_WIDTH-1:0] ins,
                            input logic ld, input logic fl, input logic rs);
    int  held;
    held = exp_q.size();
    if (rs) begin
      exp_q.delete();
      m_ir   = '0;
      m_irv  = 1'b0;
      m_miss = 1'b0;
    end else if (fl) begin
      exp_q.delete();
      m_irv  = 1'b0;
      m_miss = 1'b0;
    end else begin
      if (ld && held > 0) begin
        m_ir  = exp_q.pop_front();
        m_irv = 1'b1;
      end
      m_miss = ld && (held == 0);
      if (v && held < DEPTH) exp_q.push_back(ins);
    end
  endtask

  task automatic check_model();
    int n;
    n = exp_q.size();
    chk("m_opcode",    int'(opcode),    int'(m_ir[INS_WIDTH-1 -: OPCODE_WIDTH]));
    chk("m_data_out",  int'(data_out),  int'(m_ir[DW-1:0]));
    chk("m_ir_valid",  int'(ir_valid),  int'(m_irv));
    chk("m_count",     int'(count),     n);
    chk("m_full",      int'(full),      int'(n == DEPTH));
    chk("m_empty",     int'(empty),     int'(n == 0));
    chk("m_load_miss", int'(load_miss), int'(m_miss));
  endtask

  // ---------------- driver ----------------
  // Entered #1 after a rising edge; leaves #1 after the next one.
  task automatic step(input logic v, input logic [INS_WIDTH-1:0] ins,
                      input logic ld, input logic fl, input logic rs);
    ins_valid   = v;
    instruction = ins;
    LoadIR      = ld;
    flush       = fl;
    reset       = rs;
    #1;
    chk("ins_ready", int'(ins_ready), int'(exp_q.size() < DEPTH));
    @(posedge clock);
    model_step(v, ins, ld, fl, rs);
    #1;
    check_model();
  endtask

  task automatic expect_out(input string tag, input logic [3:0] op, input logic [3:0] dat,
                            input int cnt, input logic irv, input logic miss);
    chk({tag, "_opcode"},    int'(opcode),    int'(op));
    chk({tag, "_data_out"},  int'(data_out),  int'(dat));
    chk({tag, "_count"},     int'(count),     cnt);
    chk({tag, "_ir_valid"},  int'(ir_valid),  int'(irv));
    chk({tag, "_load_miss"}, int'(load_miss), int'(miss));
    chk({tag, "_full"},      int'(full),      int'(cnt == DEPTH));
    chk({tag, "_empty"},     int'(empty),     int'(cnt == 0));
  endtask

  // ---------------- vector table ----------------
  typedef struct {
    logic       v;
    logic [7:0] ins;
    logic       ld;
    logic [3:0] op;
    logic [3:0] dat;
    int         cnt;
    logic       irv;
    logic       miss;
  } vec_t;

  vec_t vecs[$];

  function automatic vec_t mk(logic v, logic [7:0] ins, logic ld,
                              logic [3:0] op, logic [3:0] dat, int cnt,
                              logic irv, logic miss);
    vec_t r;
    r.v = v; r.ins = ins; r.ld = ld; r.op = op; r.dat = dat;
    r.cnt = cnt; r.irv = irv; r.miss = miss;
    return r;
  endfunction

  initial begin
    // Push 0x4F then idle: IR stays at reset value.
    vecs.push_back(mk(1, 8'h4F, 0, 4'h0, 4'h0, 1, 0, 0));
    vecs.push_back(mk(0, 8'h00, 0, 4'h0, 4'h0, 1, 0, 0));
    vecs.push_back(mk(0, 8'hAA, 0, 4'h0, 4'h0, 1, 0, 0));
    // Push 0xC3, then two loads in FIFO order.
    vecs.push_back(mk(1, 8'hC3, 0, 4'h0, 4'h0, 2, 0, 0));
    vecs.push_back(mk(0, 8'h00, 1, 4'h4, 4'hF, 1, 1, 0));
    vecs.push_back(mk(0, 8'h00, 1, 4'hC, 4'h3, 0, 1, 0));
    // Load on empty with a same-cycle push: miss, no bypass.
    vecs.push_back(mk(1, 8'h3C, 1, 4'hC, 4'h3, 1, 1, 1));
    vecs.push_back(mk(0, 8'h00, 0, 4'hC, 4'h3, 1, 1, 0));
    vecs.push_back(mk(0, 8'h00, 1, 4'h3, 4'hC, 0, 1, 0));
    // Five words with valid held; the fifth is refused while full.
    vecs.push_back(mk(1, 8'h10, 0, 4'h3, 4'hC, 1, 1, 0));
    vecs.push_back(mk(1, 8'h11, 0, 4'h3, 4'hC, 2, 1, 0));
    vecs.push_back(mk(1, 8'h12, 0, 4'h3, 4'hC, 3, 1, 0));
    vecs.push_back(mk(1, 8'h13, 0, 4'h3, 4'hC, 4, 1, 0));
    vecs.push_back(mk(1, 8'h14, 0, 4'h3, 4'hC, 4, 1, 0));
    // Push+pop while full: only the pop happens.
    vecs.push_back(mk(1, 8'h99, 1, 4'h1, 4'h0, 3, 1, 0));
    // Push+pop mid-occupancy: count holds, tail wraps.
    vecs.push_back(mk(1, 8'h77, 1, 4'h1, 4'h1, 3, 1, 0));
    vecs.push_back(mk(0, 8'h00, 1, 4'h1, 4'h2, 2, 1, 0));
    vecs.push_back(mk(0, 8'h00, 1, 4'h1, 4'h3, 1, 1, 0));
    vecs.push_back(mk(0, 8'h00, 1, 4'h7, 4'h7, 0, 1, 0));
  end

  // ---------------- test sequence ----------------
  initial begin
    ins_valid   = 1'b0;
    instruction = '0;
    LoadIR      = 1'b0;
    flush       = 1'b0;
    reset       = 1'b1;
    @(posedge clock);
    @(posedge clock);
    #1;
    // Reset state.
    expect_out("reset", 4'h0, 4'h0, 0, 0, 0);
    chk("reset_ins_ready", int'(ins_ready), 1);

    for (int i = 0; i < vecs.size(); i++) begin
      step(vecs[i].v, vecs[i].ins, vecs[i].ld, 1'b0, 1'b0);
      expect_out($sformatf("vec%0d", i), vecs[i].op, vecs[i].dat,
                 vecs[i].cnt, vecs[i].irv, vecs[i].miss);
    end

    // Flush with three queued words; push and LoadIR in the flush cycle are ignored.
    step(1, 8'hA1, 0, 0, 0);
    step(1, 8'hA2, 0, 0, 0);
    step(1, 8'hA3, 0, 0, 0);
    step(1, 8'hA4, 1, 1, 0);
    expect_out("flush", 4'h7, 4'h7, 0, 0, 0);
    step(0, 8'h00, 1, 0, 0);
    expect_out("post_flush_miss", 4'h7, 4'h7, 0, 0, 1);

    // Reset mid-stream with IR=0xC3 and two queued words.
    step(1, 8'hC3, 0, 0, 0);
    step(1, 8'h11, 1, 0, 0);
    step(1, 8'h22, 0, 0, 0);
    expect_out("pre_reset", 4'hC, 4'h3, 2, 1, 0);
    step(1, 8'h55, 1, 1, 1);
    expect_out("mid_reset", 4'h0, 4'h0, 0, 0, 0);
    chk("mid_reset_ins_ready", int'(ins_ready), 1);
    step(1, 8'h6B, 0, 0, 0);
    step(0, 8'h00, 1, 0, 0);
    expect_out("after_reset_load", 4'h6, 4'hB, 0, 1, 0);

    // Randomized traffic against the model; flush and reset kept rare.
    for (int i = 0; i < 3000; i++) begin
      step(logic'($urandom_range(0, 99) < 60),
           INS_WIDTH'($urandom),
           logic'($urandom_range(0, 99) < 45),
           logic'($urandom_range(0, 99) < 3),
           logic'($urandom_range(0, 199) < 2));
    end

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
